rxuart: RTL and testbench

- UART receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first, idle-high line.
- Pairs with the team's existing transmitter on the same 16 MHz board; same default rate, 9600 baud.
- Oversamples the line at 16x baud, validates the start bit, samples each bit mid-cell.
- Presents each received byte with a one-cycle strobe; flags framing errors.

---
 rtl/rxuart_pkg.sv | 28 ++
 rtl/rxuart_if.sv | 13 +
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/rxuart.sv | 139 +++++++++++++
 tb/tb_rxuart.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rxuart_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encoding, framing constants, result payload.
package rxuart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned SUB_W      = $clog2(OVERSAMPLE);
    localparam int unsigned IDX_W      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 valid;
        logic                 frame_err;
    } rx_result_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rxuart_if.sv
// Receiver bus: serial input plus the byte/strobe/status outputs.
interface rxuart_if;

    logic                            i_uart_rx;
    logic [rxuart_pkg::DATA_BITS-1:0] o_data;
    logic                            o_valid;
    logic                            o_frame_err;
    logic                            o_busy;

    modport master (input i_uart_rx, output o_data, output o_valid, output o_frame_err, output o_busy);
    modport slave  (output i_uart_rx, input o_data, input o_valid, input o_frame_err, input o_busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: pulses once every CLK_HZ/(BAUD*OVERSAMPLE) clocks, restartable.
module uart_baud_tick #(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick_c
);

    localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_baud_tick: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_tick_c = (cnt_q == CNT_W'(DIV - 1));

    // Restart realigns the tick phase to an external event (the start edge).
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_restart || o_tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rxuart.sv
// 8N1 UART receiver with 16x oversampling and framing-error detection.
// Define RXUART_MAJORITY_EN for 2-of-3 voting over sub-samples 6/7/8.
module rxuart
    import rxuart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 16000000,
    parameter int unsigned BAUD   = 9600
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    rxuart_if.master  bus
);

    logic [1:0]           sync_q, sync_d;
    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [SUB_W-1:0]     s_q, s_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    rx_result_t           result_q, result_d;
    logic                 busy_q, busy_d;
    logic                 tick_c, restart_c, sample_c, end_c, bit_c;

`ifdef RXUART_MAJORITY_EN
    localparam int unsigned SAMPLE_S = MID_SAMPLE + 1;
    logic [1:0] vote_q, vote_d;
    assign bit_c = majority3(vote_q[0], vote_q[1], rx_s);
`else
    localparam int unsigned SAMPLE_S = MID_SAMPLE;
    assign bit_c = rx_s;
`endif

    uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (restart_c),
        .o_tick_c  (tick_c)
    );

    assign sync_d   = {sync_q[0], bus.i_uart_rx};
    assign rx_s     = sync_q[1];
    assign sample_c = tick_c && (s_q == SUB_W'(SAMPLE_S));
    assign end_c    = tick_c && (s_q == SUB_W'(OVERSAMPLE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rx_s) state_d = ST_START;
            ST_START: begin
                if (sample_c && bit_c) state_d = ST_IDLE;
                else if (end_c)        state_d = ST_DATA;
            end
            ST_DATA:  if (end_c && (bit_idx_q == IDX_W'(DATA_BITS - 1))) state_d = ST_STOP;
            // Good stop leaves half a bit early so the next start edge is caught cleanly.
            ST_STOP:  if (sample_c) state_d = bit_c ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        restart_c          = 1'b0;
        s_d                = tick_c ? (s_q + SUB_W'(1)) : s_q;
        bit_idx_d          = bit_idx_q;
        shreg_d            = shreg_q;
        result_d           = result_q;
        result_d.valid     = 1'b0;
        result_d.frame_err = 1'b0;
        busy_d             = (state_q != ST_IDLE);
`ifdef RXUART_MAJORITY_EN
        vote_d = vote_q;
        if (tick_c && (s_q == SUB_W'(MID_SAMPLE - 1))) vote_d[0] = rx_s;
        if (tick_c && (s_q == SUB_W'(MID_SAMPLE)))     vote_d[1] = rx_s;
`endif
        case (state_q)
            ST_IDLE: begin
                s_d       = '0;
                bit_idx_d = '0;
                restart_c = !rx_s;
            end
            ST_DATA: begin
                if (sample_c) shreg_d = {bit_c, shreg_q[DATA_BITS-1:1]};
                if (end_c)    bit_idx_d = bit_idx_q + IDX_W'(1);
            end
            ST_STOP: begin
                if (sample_c && bit_c) begin
                    result_d.data  = shreg_q;
                    result_d.valid = 1'b1;
                end else if (sample_c) begin
                    result_d.frame_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Synchronizer resets high so reset release never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q    <= 2'b11;
            s_q       <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_q       <= s_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
        end
    end

`ifdef RXUART_MAJORITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end
`endif

    assign bus.o_data      = result_q.data;
    assign bus.o_valid     = result_q.valid;
    assign bus.o_frame_err = result_q.frame_err;
    assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_rxuart.sv
// Directed bench for rxuart; line rate raised so one bit is 128 clocks (DIV=8).
module tb_rxuart;

    localparam int unsigned CLK_HZ   = 16000000;
    localparam int unsigned BAUD     = 125000;
    localparam int          BIT_CLKS = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         long_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] last_data  = 8'h00;

    rxuart_if bus();

    rxuart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #31 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.o_valid) begin
            valid_cnt = valid_cnt + 1;
            last_data = bus.o_data;
        end
        if (bus.o_frame_err) ferr_cnt = ferr_cnt + 1;
        if (bus.o_valid && bus.o_frame_err) both_cnt = both_cnt + 1;
        if (bus.o_valid && prev_valid) long_cnt = long_cnt + 1;
        prev_valid = bus.o_valid;
    end

    // Drives one frame; the line is left at the stop level.
    task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_val, input int stop_clks);
        bus.i_uart_rx = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.i_uart_rx = b[i];
            repeat (bclk) @(negedge clk);
        end
        bus.i_uart_rx = stop_val;
        repeat (stop_clks) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.o_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.o_data); end
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", bus.o_frame_err); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL release_busy: got %b want 0", bus.o_busy); end
        n_cmp++; if (valid_cnt !== 0) begin n_err++; $display("FAIL release_valid_cnt: got %0d want 0", valid_cnt); end
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'h55, BIT_CLKS, 1'b1, BIT_CLKS);
        n_cmp++; if (valid_cnt !== v0 + 1) begin n_err++; $display("FAIL b2b_first_cnt: got %0d want %0d", valid_cnt, v0 + 1); end
        n_cmp++; if (last_data !== 8'h55) begin n_err++; $display("FAIL b2b_first_data: got %h want 55", last_data); end
        send_byte(8'hA3, BIT_CLKS, 1'b1, BIT_CLKS);
        repeat (BIT_CLKS) @(negedge clk);
        n_cmp++; if (valid_cnt !== v0 + 2) begin n_err++; $display("FAIL b2b_second_cnt: got %0d want %0d", valid_cnt, v0 + 2); end
        n_cmp++; if (last_data !== 8'hA3) begin n_err++; $display("FAIL b2b_second_data: got %h want a3", last_data); end
        n_cmp++; if (bus.o_data !== 8'hA3) begin n_err++; $display("FAIL b2b_hold_data: got %h want a3", bus.o_data); end
        n_cmp++; if (ferr_cnt !== f0) begin n_err++; $display("FAIL b2b_ferr: got %0d want %0d", ferr_cnt, f0); end
    endtask

    task automatic test_glitch();
        int v0, f0, k;
        v0 = valid_cnt; f0 = ferr_cnt; k = 0;
        bus.i_uart_rx = 1'b0;
        repeat (24) @(negedge clk);
        bus.i_uart_rx = 1'b1;
        n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_seen: got %b want 1", bus.o_busy); end
        while (bus.o_busy === 1'b1 && k < BIT_CLKS) begin @(negedge clk); k++; end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_clear: got %b want 0 within %0d clks", bus.o_busy, BIT_CLKS); end
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_cmp++; if (valid_cnt !== v0) begin n_err++; $display("FAIL glitch_valid: got %0d want %0d", valid_cnt, v0); end
        n_cmp++; if (ferr_cnt !== f0) begin n_err++; $display("FAIL glitch_ferr: got %0d want %0d", ferr_cnt, f0); end
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, BIT_CLKS, 1'b0, 2 * BIT_CLKS);
        n_cmp++; if (ferr_cnt !== f0 + 1) begin n_err++; $display("FAIL ferr_pulse: got %0d want %0d", ferr_cnt, f0 + 1); end
        n_cmp++; if (valid_cnt !== v0) begin n_err++; $display("FAIL ferr_no_valid: got %0d want %0d", valid_cnt, v0); end
        n_cmp++; if (bus.o_data !== 8'hA3) begin n_err++; $display("FAIL ferr_data_hold: got %h want a3", bus.o_data); end
        n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_break: got %b want 1", bus.o_busy); end
        bus.i_uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release: got %b want 0", bus.o_busy); end
        repeat (BIT_CLKS) @(negedge clk);
        send_byte(8'h3C, BIT_CLKS, 1'b1, BIT_CLKS);
        n_cmp++; if (valid_cnt !== v0 + 1) begin n_err++; $display("FAIL ferr_next_cnt: got %0d want %0d", valid_cnt, v0 + 1); end
        n_cmp++; if (last_data !== 8'h3C) begin n_err++; $display("FAIL ferr_next_data: got %h want 3c", last_data); end
    endtask

    task automatic test_rate_tol();
        logic [7:0] pats [3];
        int         rates [2];
        int         v0;
        pats  = '{8'h00, 8'hFF, 8'hC3};
        rates = '{124, 132};
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 3; p++) begin
                v0 = valid_cnt;
                send_byte(pats[p], rates[r], 1'b1, rates[r]);
                n_cmp++; if (valid_cnt !== v0 + 1) begin n_err++; $display("FAIL rate_cnt bit=%0d pat=%h: got %0d want %0d", rates[r], pats[p], valid_cnt, v0 + 1); end
                n_cmp++; if (last_data !== pats[p]) begin n_err++; $display("FAIL rate_data bit=%0d: got %h want %h", rates[r], last_data, pats[p]); end
            end
        end
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        bus.i_uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        bus.i_uart_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        bus.i_uart_rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_pre: got %b want 1", bus.o_busy); end
        #5 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %h want 00", bus.o_data); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", bus.o_busy); end
        n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_strobes: got %b%b want 00", bus.o_valid, bus.o_frame_err); end
        bus.i_uart_rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        v0 = valid_cnt;
        send_byte(8'h7E, BIT_CLKS, 1'b1, BIT_CLKS);
        n_cmp++; if (valid_cnt !== v0 + 1) begin n_err++; $display("FAIL midrst_next_cnt: got %0d want %0d", valid_cnt, v0 + 1); end
        n_cmp++; if (bus.o_data !== 8'h7E) begin n_err++; $display("FAIL midrst_next_data: got %h want 7e", bus.o_data); end
    endtask

    task automatic test_spike();
        int v0;
        v0 = valid_cnt;
        bus.i_uart_rx = 1'b0;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        bus.i_uart_rx = 1'b1;
        @(negedge clk);
        bus.i_uart_rx = 1'b0;
        repeat (BIT_CLKS / 2 - 1 + 4 * BIT_CLKS) @(negedge clk);
        bus.i_uart_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_cmp++; if (valid_cnt !== v0 + 1) begin n_err++; $display("FAIL spike_cnt: got %0d want %0d", valid_cnt, v0 + 1); end
        n_cmp++; if ($isunknown(bus.o_data)) begin n_err++; $display("FAIL spike_x: got %h want known", bus.o_data); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL spike_busy: got %b want 0", bus.o_busy); end
`ifdef RXUART_MAJORITY_EN
        n_cmp++; if (last_data !== 8'h00) begin n_err++; $display("FAIL spike_vote_data: got %h want 00", last_data); end
`endif
    endtask

    task automatic test_pulse_rules();
        n_cmp++; if (both_cnt !== 0) begin n_err++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
        n_cmp++; if (long_cnt !== 0) begin n_err++; $display("FAIL valid_width: got %0d want 0", long_cnt); end
    endtask

    initial begin
        bus.i_uart_rx = 1'b1;
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_rate_tol();
        test_reset_mid_frame();
        test_spike();
        test_pulse_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
